// File: rtl/fetch_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fetch_arb_pkg
// Shared definitions for the fetch bus arbiter:
//   - state_e        : arbiter state encoding (RUN=0, DRAIN=1, GRANT=2, RESUME=3)
//   - NOP_OPCODE_DEF : default opcode injected as a pipeline bubble
//   - cnt_width()    : width of a counter that must hold values 0..max_val
// -----------------------------------------------------------------------------
package fetch_arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_GRANT  = 2'd2,
      ST_RESUME = 2'd3
   } state_e;

   localparam logic [7:0] NOP_OPCODE_DEF = 8'h00;

   // Width needed to hold 0..max_val, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 32'd1);
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/fetch_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// fetch_bus_arbiter_if
// Bundles the memory-bus / stage-1 signals around the fetch bus arbiter.
//   mem_data            : opcode byte from the memory data bus
//   ctrl_fetch_suppress : stage 1 controls[15], next slot is an operand/data access
//   ext_req             : external master request (level)
//   ext_grant           : bus granted to the external master
//   bus_request         : to stage 1, high while the bus is granted
//   fetch_suppress      : to stage 1, high whenever a bubble is injected
//   instruction         : opcode to stage 1
//   pc_inc              : advance the PC this cycle
//   state_dbg           : current arbiter state encoding
// Modports: master = the arbiter, slave = the surrounding bus/pipeline.
// -----------------------------------------------------------------------------
interface fetch_bus_arbiter_if;

   logic [7:0] mem_data;
   logic       ctrl_fetch_suppress;
   logic       ext_req;
   logic       ext_grant;
   logic       bus_request;
   logic       fetch_suppress;
   logic [7:0] instruction;
   logic       pc_inc;
   logic [1:0] state_dbg;

   modport master (
      input  mem_data, ctrl_fetch_suppress, ext_req,
      output ext_grant, bus_request, fetch_suppress, instruction, pc_inc, state_dbg
   );

   modport slave (
      output mem_data, ctrl_fetch_suppress, ext_req,
      input  ext_grant, bus_request, fetch_suppress, instruction, pc_inc, state_dbg
   );

endinterface

// File: rtl/fetch_bus_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Loadable down-counter that stops at zero instead of wrapping.
//   clk        : clock
//   reset_n    : synchronous active-low reset, clears the count
//   i_load     : load i_load_val (wins over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : count is zero (terminal flag)
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   // Count register: load, saturating decrement, or hold.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= {WIDTH{1'b0}};
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != {WIDTH{1'b0}})) begin
         r_count <= r_count - WIDTH'(1'b1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_zero = (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/fetch_bus_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_bus_arbiter
// Sequences opcode fetch into pipeline stage 1 and hands the memory bus to one
// external master. Before a grant the pipeline is drained with NOP bubbles; the
// PC is held while the bus is granted and for the turnaround cycle after it.
// All outputs are registered and reflect the state being entered.
//
// Ports:
//   clk     : system clock, all state changes on posedge
//   reset_n : synchronous active-low reset
//   bus     : fetch_bus_arbiter_if.master (mem_data, ctrl_fetch_suppress,
//             ext_req in; ext_grant, bus_request, fetch_suppress,
//             instruction, pc_inc, state_dbg out)
//
// Optional feature macro: FETCH_ARB_GRANT_TIMEOUT_EN
//   Defined   : a grant is forcibly released after MAX_GRANT cycles and the
//               next RUN->DRAIN is held off for COOLDOWN cycles.
//   Undefined : a grant lasts until ext_req falls.
// -----------------------------------------------------------------------------
module fetch_bus_arbiter
   import fetch_arb_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned MAX_GRANT    = 64,
   parameter int unsigned COOLDOWN     = 8,
   parameter logic [7:0]  NOP_OPCODE   = NOP_OPCODE_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fetch_bus_arbiter_if.master  bus
);

   // One shared counter width so every sat_counter instance is identical.
   localparam int unsigned CNT_MAX =
      (DRAIN_CYCLES > MAX_GRANT) ? ((DRAIN_CYCLES > COOLDOWN) ? DRAIN_CYCLES : COOLDOWN)
                                 : ((MAX_GRANT > COOLDOWN) ? MAX_GRANT : COOLDOWN);
   localparam int unsigned CNT_W = cnt_width(CNT_MAX);

   // The counter is loaded on entry to DRAIN, so the entry cycle is already one
   // of the DRAIN_CYCLES bubbles.
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 32'd1);

   state_e     r_state;
   state_e     w_state_nxt;
   logic       r_ext_grant;
   logic       r_bus_request;
   logic       r_fetch_suppress;
   logic       r_pc_inc;
   logic [7:0] r_instruction;

   logic       w_ext_grant_nxt;
   logic       w_bus_request_nxt;
   logic       w_fetch_suppress_nxt;
   logic       w_pc_inc_nxt;
   logic [7:0] w_instruction_nxt;

   logic       w_drain_load;
   logic       w_drain_dec;
   logic       w_drain_zero;
   logic       w_cool_ok;

   sat_counter #(.WIDTH(CNT_W)) u_drain_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_drain_load),
      .i_load_val (DRAIN_LOAD),
      .i_dec      (w_drain_dec),
      .o_zero     (w_drain_zero)
   );

`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
   localparam logic [CNT_W-1:0] GRANT_LOAD = CNT_W'(MAX_GRANT - 32'd1);
   localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN);

   logic w_grant_load;
   logic w_grant_dec;
   logic w_grant_zero;
   logic w_cool_load;
   logic w_cool_zero;

   sat_counter #(.WIDTH(CNT_W)) u_grant_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_grant_load),
      .i_load_val (GRANT_LOAD),
      .i_dec      (w_grant_dec),
      .o_zero     (w_grant_zero)
   );

   // Cooldown runs down every cycle from the forced release (the RESUME cycle
   // included), which leaves exactly COOLDOWN RUN cycles before a new DRAIN.
   sat_counter #(.WIDTH(CNT_W)) u_cooldown (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_cool_load),
      .i_load_val (COOL_LOAD),
      .i_dec      (1'b1),
      .o_zero     (w_cool_zero)
   );

   assign w_cool_ok = w_cool_zero;
`else
   assign w_cool_ok = 1'b1;
`endif

   // Next-state, counter control and output values for the state being entered.
   always_comb begin
      w_state_nxt  = r_state;
      w_drain_load = 1'b0;
      w_drain_dec  = 1'b0;
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
      w_grant_load = 1'b0;
      w_grant_dec  = 1'b0;
      w_cool_load  = 1'b0;
`endif
      w_ext_grant_nxt      = 1'b0;
      w_bus_request_nxt    = 1'b0;
      w_fetch_suppress_nxt = 1'b1;
      w_pc_inc_nxt         = 1'b0;
      w_instruction_nxt    = NOP_OPCODE;

      case (r_state)
         ST_RUN: begin
            // Only leave on an opcode slot so a multi-byte instruction is never split.
            if (bus.ext_req && !bus.ctrl_fetch_suppress && w_cool_ok) begin
               w_state_nxt  = ST_DRAIN;
               w_drain_load = 1'b1;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!bus.ext_req) begin
               w_state_nxt = ST_RUN;
            end else if (w_drain_zero) begin
               w_state_nxt = ST_GRANT;
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
               w_grant_load = 1'b1;
`endif
            end else begin
               w_drain_dec = 1'b1;
            end
         end
         ST_GRANT: begin
            if (!bus.ext_req) begin
               w_state_nxt = ST_RESUME;
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
            end else if (w_grant_zero) begin
               w_state_nxt = ST_RESUME;
               w_cool_load = 1'b1;
            end else begin
               w_state_nxt = ST_GRANT;
               w_grant_dec = 1'b1;
`else
            end else begin
               w_state_nxt = ST_GRANT;
`endif
            end
         end
         ST_RESUME: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      case (w_state_nxt)
         ST_RUN: begin
            if (!bus.ctrl_fetch_suppress) begin
               w_instruction_nxt    = bus.mem_data;
               w_fetch_suppress_nxt = 1'b0;
               w_pc_inc_nxt         = 1'b1;
            end else begin
               w_instruction_nxt    = NOP_OPCODE;
               w_fetch_suppress_nxt = 1'b1;
               w_pc_inc_nxt         = 1'b0;
            end
         end
         ST_GRANT: begin
            w_ext_grant_nxt   = 1'b1;
            w_bus_request_nxt = 1'b1;
         end
         ST_DRAIN, ST_RESUME: begin
            w_ext_grant_nxt   = 1'b0;
            w_bus_request_nxt = 1'b0;
         end
         default: begin
            w_ext_grant_nxt   = 1'b0;
            w_bus_request_nxt = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset puts a NOP on stage 1 and drops any grant at once.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state          <= ST_RUN;
         r_ext_grant      <= 1'b0;
         r_bus_request    <= 1'b0;
         r_fetch_suppress <= 1'b1;
         r_pc_inc         <= 1'b0;
         r_instruction    <= NOP_OPCODE;
      end else begin
         r_state          <= w_state_nxt;
         r_ext_grant      <= w_ext_grant_nxt;
         r_bus_request    <= w_bus_request_nxt;
         r_fetch_suppress <= w_fetch_suppress_nxt;
         r_pc_inc         <= w_pc_inc_nxt;
         r_instruction    <= w_instruction_nxt;
      end
   end

   assign bus.ext_grant      = r_ext_grant;
   assign bus.bus_request    = r_bus_request;
   assign bus.fetch_suppress = r_fetch_suppress;
   assign bus.pc_inc         = r_pc_inc;
   assign bus.instruction    = r_instruction;
   assign bus.state_dbg      = r_state;

endmodule

// File: tb/tb_fetch_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fetch_bus_arbiter
// Directed scenarios plus a randomized run against a cycle-level reference of
// the arbiter's rules. Output vectors are packed as
// {state_dbg, ext_grant, bus_request, fetch_suppress, pc_inc, instruction}.
// -----------------------------------------------------------------------------
module tb_fetch_bus_arbiter;

   localparam int unsigned TB_DRAIN = 2;
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
   localparam int unsigned TB_MAX_GRANT = 4;
`else
   localparam int unsigned TB_MAX_GRANT = 64;
`endif
   localparam int unsigned TB_COOLDOWN = 8;
   localparam int unsigned GRANT_RUN   = (TB_MAX_GRANT < 5) ? TB_MAX_GRANT : 5;
   localparam logic [7:0]  NOP         = 8'h00;

   logic clk = 1'b0;
   logic reset_n;

   fetch_bus_arbiter_if ifc();

   fetch_bus_arbiter #(
      .DRAIN_CYCLES (TB_DRAIN),
      .MAX_GRANT    (TB_MAX_GRANT),
      .COOLDOWN     (TB_COOLDOWN),
      .NOP_OPCODE   (NOP)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: phase number plus cycle counts, updated once per posedge.
   int         m_phase     = 0;
   int         m_drained   = 0;
   int         m_granted   = 0;
   longint     m_edge      = 0;
   longint     m_forced_at = -1000;
   logic [7:0] e_instr;
   logic       e_grant, e_busreq, e_fs, e_pc;

   function automatic logic [13:0] mk(input logic [1:0] st, input logic g, input logic b,
                                      input logic f, input logic p, input logic [7:0] ins);
      return {st, g, b, f, p, ins};
   endfunction

   function automatic logic [13:0] dut_vec();
      return {ifc.state_dbg, ifc.ext_grant, ifc.bus_request, ifc.fetch_suppress,
              ifc.pc_inc, ifc.instruction};
   endfunction

   function automatic logic [13:0] exp_vec();
      return mk(2'(m_phase), e_grant, e_busreq, e_fs, e_pc, e_instr);
   endfunction

   function automatic bit cooldown_over();
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
      return (m_edge - m_forced_at) > longint'(TB_COOLDOWN);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_edge(input logic rn, input logic req, input logic sup,
                             input logic [7:0] data);
      int nxt;
      m_edge++;
      if (!rn) begin
         m_phase = 0; m_drained = 0; m_granted = 0; m_forced_at = -1000;
         e_grant = 1'b0; e_busreq = 1'b0; e_fs = 1'b1; e_pc = 1'b0; e_instr = NOP;
      end else begin
         nxt = m_phase;
         case (m_phase)
            0: if (req && !sup && cooldown_over()) begin nxt = 1; m_drained = 0; end
            1: begin
               if (!req) nxt = 0;
               else begin
                  m_drained++;
                  if (m_drained >= int'(TB_DRAIN)) begin nxt = 2; m_granted = 0; end
               end
            end
            2: begin
               m_granted++;
               if (!req) nxt = 3;
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
               else if (m_granted >= int'(TB_MAX_GRANT)) begin nxt = 3; m_forced_at = m_edge; end
`endif
            end
            3: nxt = 0;
            default: nxt = 0;
         endcase
         m_phase  = nxt;
         e_grant  = (nxt == 2);
         e_busreq = (nxt == 2);
         if (nxt == 0 && !sup) begin
            e_instr = data; e_fs = 1'b0; e_pc = 1'b1;
         end else begin
            e_instr = NOP; e_fs = 1'b1; e_pc = 1'b0;
         end
      end
   endtask

   // Advance one clock, update the reference, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      model_edge(reset_n, ifc.ext_req, ifc.ctrl_fetch_suppress, ifc.mem_data);
      #1;
   endtask

   task automatic test_reset();
      logic [13:0] want;
      reset_n = 1'b0; ifc.ext_req = 1'b0; ifc.ctrl_fetch_suppress = 1'b0; ifc.mem_data = 8'h3A;
      tick(); tick();
      want = mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL reset_state: got %h expected %h", dut_vec(), want);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         want = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3A);
         n_cmp++;
         if (dut_vec() !== want) begin
            n_err++; $display("FAIL run_fetch_3A: got %h expected %h", dut_vec(), want);
         end
      end
      ifc.mem_data = 8'h5C;
      tick();
      n_cmp++;
      if (ifc.instruction !== 8'h5C || ifc.pc_inc !== 1'b1) begin
         n_err++; $display("FAIL run_fetch_5C: got instr %h pc_inc %b expected 5c 1",
                           ifc.instruction, ifc.pc_inc);
      end
   endtask

   task automatic test_drain_grant();
      logic [13:0] want;
      ifc.ext_req = 1'b1; ifc.ctrl_fetch_suppress = 1'b0; ifc.mem_data = 8'h77;
      for (int i = 0; i < int'(TB_DRAIN); i++) begin
         tick();
         want = mk(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, NOP);
         n_cmp++;
         if (dut_vec() !== want) begin
            n_err++; $display("FAIL drain_cycle%0d: got %h expected %h", i, dut_vec(), want);
         end
      end
      for (int i = 0; i < int'(GRANT_RUN); i++) begin
         tick();
         want = mk(2'd2, 1'b1, 1'b1, 1'b1, 1'b0, NOP);
         n_cmp++;
         if (dut_vec() !== want) begin
            n_err++; $display("FAIL grant_cycle%0d: got %h expected %h", i, dut_vec(), want);
         end
      end
      ifc.ext_req = 1'b0;
      tick();
      want = mk(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, NOP);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL resume_cycle: got %h expected %h", dut_vec(), want);
      end
      tick();
      want = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL run_after_resume: got %h expected %h", dut_vec(), want);
      end
   endtask

   task automatic test_drain_abort();
      logic [13:0] want;
      ifc.ext_req = 1'b1; ifc.mem_data = 8'h42;
      tick();
      ifc.ext_req = 1'b0;
      tick();
      want = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL drain_abort: got %h expected %h", dut_vec(), want);
      end
   endtask

   task automatic test_deferral();
      logic [13:0] want;
      ifc.ext_req = 1'b1; ifc.ctrl_fetch_suppress = 1'b1; ifc.mem_data = 8'hC3;
      for (int i = 0; i < 3; i++) begin
         tick();
         want = mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, NOP);
         n_cmp++;
         if (dut_vec() !== want) begin
            n_err++; $display("FAIL defer_nop%0d: got %h expected %h", i, dut_vec(), want);
         end
      end
      ifc.ctrl_fetch_suppress = 1'b0;
      tick();
      want = mk(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, NOP);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL defer_then_drain: got %h expected %h", dut_vec(), want);
      end
      ifc.ext_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      logic [13:0] want;
      ifc.ext_req = 1'b1; ifc.ctrl_fetch_suppress = 1'b0;
      for (int i = 0; i <= int'(TB_DRAIN); i++) tick();
      n_cmp++;
      if (ifc.ext_grant !== 1'b1) begin
         n_err++; $display("FAIL pre_reset_grant: got %b expected 1", ifc.ext_grant);
      end
      reset_n = 1'b0;
      tick();
      want = mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL reset_mid_grant: got %h expected %h", dut_vec(), want);
      end
      reset_n = 1'b1; ifc.ext_req = 1'b0; ifc.mem_data = 8'h9E;
      tick();
      want = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h9E);
      n_cmp++;
      if (dut_vec() !== want) begin
         n_err++; $display("FAIL no_resume_after_reset: got %h expected %h", dut_vec(), want);
      end
   endtask

`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
   task automatic test_timeout();
      int seq [16] = '{1, 1, 2, 2, 2, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      ifc.ext_req = 1'b1; ifc.ctrl_fetch_suppress = 1'b0; ifc.mem_data = 8'h11;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_cmp++;
         if (ifc.state_dbg !== 2'(seq[i])) begin
            n_err++; $display("FAIL timeout_seq%0d: got %0d expected %0d", i, ifc.state_dbg, seq[i]);
         end
      end
      ifc.ext_req = 1'b0;
      tick();
   endtask
`endif

   task automatic test_random();
      logic prev_grant;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if ($urandom_range(0, 5) == 0) ifc.ext_req = ~ifc.ext_req;
         ifc.ctrl_fetch_suppress = ($urandom_range(0, 2) == 0);
         ifc.mem_data = 8'($urandom);
         reset_n = ($urandom_range(0, 79) != 0);
         prev_grant = ifc.ext_grant;
         tick();
         n_cmp++;
         if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL random_cyc%0d: got %h expected %h", cyc, dut_vec(), exp_vec());
         end
         n_cmp++;
         if (ifc.pc_inc === 1'b1 && (ifc.ext_grant === 1'b1 || prev_grant === 1'b1)) begin
            n_err++; $display("FAIL pc_inc_near_grant%0d: got pc_inc 1 grant %b prev %b expected pc_inc 0",
                              cyc, ifc.ext_grant, prev_grant);
         end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      ifc.ext_req = 1'b0;
      ifc.ctrl_fetch_suppress = 1'b0;
      ifc.mem_data = 8'h00;
      test_reset();
      test_drain_grant();
      test_drain_abort();
      test_deferral();
      test_reset_mid_grant();
`ifdef FETCH_ARB_GRANT_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
